r16_pipe_ctrl: RTL and testbench

R16_PIPE_CTRL -- requirements
Module: r16_pipe_ctrl

---
 rtl/r16_ctrl_pkg.sv | 27 ++
 rtl/r16_pipe_ctrl_if.sv | 27 ++
 rtl/r16_ctrl_delay.sv | 31 +++
 rtl/r16_pipe_ctrl.sv | 115 +++++++++++
 tb/tb_r16_pipe_ctrl.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/r16_ctrl_pkg.sv
// Shared definitions for the radix-16 pipeline controller: FSM states,
// pass count and the group-start masks for the radix-16/radix-4 passes.
package r16_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int unsigned STAGES     = 4;
  localparam logic [1:0]  LAST_STAGE = 2'(STAGES - 1);

  // Radix-16 passes start a group every 16 samples; the final radix-4
  // remainder pass starts a group every 4 samples.
  localparam logic [3:0] R16_GROUP_MASK = 4'hF;
  localparam logic [3:0] R4_GROUP_MASK  = 4'h3;

  // Group-start flag for the given pass from the low sample-index bits.
  function automatic logic group_start(input logic [1:0] stage, input logic [3:0] low);
    logic [3:0] mask;
    mask = (stage == LAST_STAGE) ? R4_GROUP_MASK : R16_GROUP_MASK;
    return (low & mask) == 4'b0000;
  endfunction

endpackage

// File: rtl/r16_pipe_ctrl_if.sv
// Handshake and control bus between the upstream sample source / butterfly
// datapath (master side) and the pipeline controller (slave side).
interface r16_pipe_ctrl_if #(
  parameter int unsigned N_LOG2 = 14
);
  logic              start;
  logic              inverse;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        stage_idx;
  logic [N_LOG2-1:0] sample_idx;
  logic              Ac_out;
  logic              ninv2_en;
  logic              out_valid;
  logic              busy;
  logic              done;

  modport master (
    output start, inverse, in_valid,
    input  in_ready, stage_idx, sample_idx, Ac_out, ninv2_en, out_valid, busy, done
  );

  modport slave (
    input  start, inverse, in_valid,
    output in_ready, stage_idx, sample_idx, Ac_out, ninv2_en, out_valid, busy, done
  );
endinterface

// File: rtl/r16_ctrl_delay.sv
// Fixed-depth shift register used to align the per-sample control bits with
// the butterfly datapath output.
module r16_ctrl_delay #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] pipe [DEPTH];

  // Shift one position per cycle; reset clears every stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign q = pipe[DEPTH-1];

endmodule

// File: rtl/r16_pipe_ctrl.sv
// Pass/sample sequencer for a 4-pass radix-16 FFT pipeline. Accepts one
// sample per handshake, tracks the pass and index, and emits group-start and
// scaling flags aligned to the datapath output after PIPE_LAT cycles.
module r16_pipe_ctrl
  import r16_ctrl_pkg::*;
#(
  parameter int unsigned N_LOG2   = 14,
  parameter int unsigned PIPE_LAT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  r16_pipe_ctrl_if.slave       bus
);

  localparam int unsigned DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  state_t            state_q, state_d;
  logic [1:0]        stage_q;
  logic [N_LOG2-1:0] sample_q;
  logic              inv_q;
  logic [DW-1:0]     drain_q;

  logic              xfer;
  logic              sample_max;
  logic              last_xfer;
  logic              drain_last;
  logic              raw_ac;
  logic              raw_ninv;
  logic [2:0]        dly_in;
  logic [2:0]        dly_out;

  assign xfer       = bus.in_valid && (state_q == ST_RUN);
  assign sample_max = &sample_q;
  assign last_xfer  = xfer && sample_max && (stage_q == LAST_STAGE);
  assign drain_last = (drain_q == DW'(PIPE_LAT - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start)  state_d = ST_RUN;
      ST_RUN:   if (last_xfer)  state_d = ST_DRAIN;
      ST_DRAIN: if (drain_last) state_d = ST_DONE;
      ST_DONE:                  state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Pass/sample counters and the inverse latch; the final transfer leaves
  // the counters parked on the last index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q  <= '0;
      sample_q <= '0;
      inv_q    <= 1'b0;
    end else if ((state_q == ST_IDLE) && bus.start) begin
      stage_q  <= '0;
      sample_q <= '0;
      inv_q    <= bus.inverse;
    end else if (xfer && !last_xfer) begin
      if (sample_max) begin
        sample_q <= '0;
        stage_q  <= stage_q + 2'd1;
      end else begin
        sample_q <= sample_q + N_LOG2'(1);
      end
    end
  end

  // Drain timer: counts cycles spent waiting for the datapath to empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_q <= '0;
    end else if (state_q == ST_DRAIN) begin
      drain_q <= drain_q + DW'(1);
    end else begin
      drain_q <= '0;
    end
  end

  // Flags are gated by the transfer strobe before the delay line so the
  // aligned outputs can only be high on valid beats.
  assign raw_ac   = group_start(stage_q, sample_q[3:0]);
  assign raw_ninv = inv_q && (stage_q == LAST_STAGE);
  assign dly_in   = {xfer, xfer && raw_ac, xfer && raw_ninv};

  r16_ctrl_delay #(
    .WIDTH(3),
    .DEPTH(PIPE_LAT)
  ) u_delay (
    .clk(clk),
    .rst(rst),
    .d  (dly_in),
    .q  (dly_out)
  );

  assign bus.in_ready   = (state_q == ST_RUN);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.stage_idx  = stage_q;
  assign bus.sample_idx = sample_q;
  assign bus.out_valid  = dly_out[2];
  assign bus.Ac_out     = dly_out[1];
  assign bus.ninv2_en   = dly_out[0];

endmodule

// File: tb/tb_r16_pipe_ctrl.sv
// Self-checking bench for r16_pipe_ctrl. Uses a reduced transform length so
// that every scenario fits in a short run; all expectations scale with N.
module tb_r16_pipe_ctrl;

  localparam int unsigned NL      = 10;
  localparam int unsigned PL      = 4;
  localparam int unsigned N       = 1 << NL;
  localparam int unsigned TOTAL   = 4 * N;
  localparam int unsigned RUN_CAP = 16 * TOTAL;

  typedef enum int {PH_IDLE, PH_RUN, PH_DRAIN, PH_DONE} phase_t;
  typedef struct {
    int unsigned cyc;
    logic        ac;
    logic        ninv;
  } beat_t;

  logic clk;
  logic rst;

  r16_pipe_ctrl_if #(.N_LOG2(NL)) bus ();

  r16_pipe_ctrl #(.N_LOG2(NL), .PIPE_LAT(PL)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // reference model state
  phase_t      ph;
  int unsigned m_k;
  logic        m_inv;
  int unsigned m_done_cyc;
  int unsigned cyc;
  beat_t       exp_q[$];

  // per-run observations of the DUT
  int unsigned beats, ninv_cnt, done_cnt;
  int unsigned ac_cnt[4];
  int unsigned first_xfer, last_xfer, first_ov, done_cyc;
  bit          seen_xfer, seen_ov;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    ph    = PH_IDLE;
    m_k   = 0;
    m_inv = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_outputs();
    logic        e_ov, e_ac, e_ninv;
    int unsigned e_stage, e_sample;
    e_ov = 1'b0; e_ac = 1'b0; e_ninv = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e_ov   = 1'b1;
      e_ac   = exp_q[0].ac;
      e_ninv = exp_q[0].ninv;
      void'(exp_q.pop_front());
    end
    e_stage  = (m_k >= TOTAL) ? 3 : m_k / N;
    e_sample = (m_k >= TOTAL) ? N - 1 : m_k % N;
    chk("in_ready",   32'(bus.in_ready),   32'(ph == PH_RUN));
    chk("busy",       32'(bus.busy),       32'(ph != PH_IDLE));
    chk("done",       32'(bus.done),       32'(ph == PH_DONE));
    chk("stage_idx",  32'(bus.stage_idx),  e_stage);
    chk("sample_idx", 32'(bus.sample_idx), e_sample);
    chk("out_valid",  32'(bus.out_valid),  32'(e_ov));
    chk("Ac_out",     32'(bus.Ac_out),     32'(e_ac));
    chk("ninv2_en",   32'(bus.ninv2_en),   32'(e_ninv));
  endtask

  task automatic observe();
    int unsigned s;
    if (bus.in_valid && bus.in_ready) begin
      if (!seen_xfer) first_xfer = cyc;
      seen_xfer = 1'b1;
      last_xfer = cyc;
    end
    if (bus.out_valid) begin
      if (!seen_ov) first_ov = cyc;
      seen_ov = 1'b1;
      s = beats / N;
      if (bus.Ac_out && s < 4) ac_cnt[s]++;
      if (bus.ninv2_en) ninv_cnt++;
      beats++;
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  // Spec-level transition rules; a transfer k carries pass k/N, index k%N.
  task automatic model_update(input logic st, input logic inv, input logic iv);
    beat_t       b;
    int unsigned s, i;
    case (ph)
      PH_IDLE: if (st) begin
        ph = PH_RUN; m_k = 0; m_inv = inv;
      end
      PH_RUN: if (iv) begin
        s      = m_k / N;
        i      = m_k % N;
        b.cyc  = cyc + PL;
        b.ac   = (s < 3) ? (i % 16 == 0) : (i % 4 == 0);
        b.ninv = m_inv && (s == 3);
        exp_q.push_back(b);
        m_k++;
        if (m_k == TOTAL) begin
          ph = PH_DRAIN;
          m_done_cyc = cyc + PL + 1;
        end
      end
      PH_DRAIN: if (cyc + 1 == m_done_cyc) ph = PH_DONE;
      default:  ph = PH_IDLE;
    endcase
  endtask

  task automatic step(input logic st, input logic inv, input logic iv);
    bus.start    = st;
    bus.inverse  = inv;
    bus.in_valid = iv;
    #1;
    check_outputs();
    observe();
    model_update(st, inv, iv);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One-cycle reset pulse; outputs must clear while rst is still high.
  task automatic reset_pulse();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check_outputs();
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
    rst = 1'b0;
  endtask

  // mode 0: in_valid held high; 1: random in_valid and inverse toggling;
  // 2: in_valid high with stray start pulses incl. the final-transfer cycle.
  task automatic run_one(input logic inv, input int mode, input int abort_k);
    logic        st, iv, inv_d;
    int unsigned guard;
    beats = 0; ninv_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 4; i++) ac_cnt[i] = 0;
    seen_xfer = 1'b0; seen_ov = 1'b0;
    first_xfer = 0; last_xfer = 0; first_ov = 0; done_cyc = 0;
    step(1'b1, inv, 1'b0);
    guard = 0;
    while (ph != PH_IDLE && guard < RUN_CAP) begin
      if (abort_k >= 0 && ph == PH_RUN && m_k == 32'(abort_k)) begin
        chk("abort_stage",  32'(bus.stage_idx),  32'(abort_k) / N);
        chk("abort_sample", 32'(bus.sample_idx), 32'(abort_k) % N);
        reset_pulse();
        return;
      end
      iv    = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      inv_d = (mode == 1) ? 1'($urandom_range(0, 1)) : inv;
      st    = (mode == 2) ? ($urandom_range(0, 15) == 0) : 1'b0;
      if (mode == 2 && ph == PH_RUN && m_k == TOTAL - 1) st = 1'b1;
      step(st, inv_d, iv);
      guard++;
    end
    chk("run_terminates", 32'(guard < RUN_CAP), 32'd1);
    chk("beats",          beats,                TOTAL);
    chk("ac_stage0",      ac_cnt[0],            N / 16);
    chk("ac_stage1",      ac_cnt[1],            N / 16);
    chk("ac_stage2",      ac_cnt[2],            N / 16);
    chk("ac_stage3",      ac_cnt[3],            N / 4);
    chk("ninv_count",     ninv_cnt,             inv ? N : 0);
    chk("first_ov_lat",   first_ov - first_xfer, PL);
    chk("done_lat",       done_cyc - last_xfer,  PL + 1);
    chk("done_count",     done_cnt,             32'd1);
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.inverse  = 1'b0;
    bus.in_valid = 1'b0;
    cyc          = 0;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs();

    run_one(1'b0, 0, -1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
    run_one(1'b1, 0, -1);
    run_one(1'b1, 1, -1);
    run_one(1'b0, 1, int'(2 * N + 500));
    run_one(1'b0, 0, -1);
    run_one(1'b1, 2, -1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
